// File: rtl/cu_uart_echo_pkg.sv
// Shared constants and state encodings for the UART echo block.
package cu_uart_echo_pkg;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  function automatic int cnt_width(input int cpb);
    return (cpb > 1) ? $clog2(cpb) : 1;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 serialiser: start bit, 8 data bits LSB first, stop bit; line idles high.
module uart_tx
  import cu_uart_echo_pkg::*;
#(
  parameter int CLKS_PER_BIT = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       start,
  output logic       busy,
  output logic       tx
);

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  assign busy = (state != TX_IDLE);

  always_ff @(posedge clk) begin
    if (state == TX_IDLE && start) shreg <= data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= TX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
    end else begin
      case (state)
        TX_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          tx      <= 1'b1;
          if (start) begin
            state <= TX_START;
            tx    <= 1'b0;
          end
        end
        TX_START: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= TX_DATA;
            tx    <= shreg[0];
          end else cnt <= cnt + 1'b1;
        end
        TX_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= TX_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[bit_idx + 3'd1];
            end
          end else cnt <= cnt + 1'b1;
        end
        TX_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= TX_IDLE;
          end else cnt <= cnt + 1'b1;
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cu_uart_echo_top.sv
// UART receiver with LED display and optional echo through a 1-entry holding buffer.
module cu_uart_echo_top
  import cu_uart_echo_pkg::*;
#(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 1000000,
  parameter int LED_W  = 8,
  parameter int ECHO   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             usb_rx,
  output logic             usb_tx,
  output logic [LED_W-1:0] led
);

  localparam int CPB   = clks_per_bit(CLK_HZ, BAUD);
  localparam int CNT_W = cnt_width(CPB);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPB / 2 - 1);

  if (CPB < 4) begin : g_cpb_chk
    $error("CLKS_PER_BIT must be at least 4");
  end
  if (LED_W < 1 || LED_W > 8) begin : g_led_chk
    $error("LED_W must be in 1..8");
  end

  logic [1:0] rst_sync;
  logic       sys_rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign sys_rst_n = rst_sync[1];

  logic [1:0]       rx_sync;
  logic             rx_line;
  logic [1:0]       settle;
  logic             armed;
  rx_state_t        rx_state;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_byte;
  logic             rx_valid;
  logic             frame_err;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) rx_sync <= 2'b11;
    else            rx_sync <= {rx_sync[0], usb_rx};
  end
  assign rx_line = rx_sync[1];

  always_ff @(posedge clk) begin
    if (rx_state == RX_DATA && rx_cnt == CNT_LAST) rx_byte <= {rx_line, rx_byte[7:1]};
  end

  // The synchroniser's reset value must not arm the receiver; wait until a
  // genuinely sampled 1 has propagated through both stages.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      settle    <= 2'b00;
      armed     <= 1'b0;
      rx_state  <= RX_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      settle   <= {settle[0], 1'b1};
      if (settle[1] && rx_line) armed <= 1'b1;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt    <= '0;
          rx_bit    <= '0;
          frame_err <= 1'b0;
          if (armed && !rx_line) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_cnt == CNT_HALF) begin
            rx_cnt   <= '0;
            rx_state <= rx_line ? RX_IDLE : RX_DATA;
          end else rx_cnt <= rx_cnt + 1'b1;
        end
        RX_DATA: begin
          if (rx_cnt == CNT_LAST) begin
            rx_cnt <= '0;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else rx_cnt <= rx_cnt + 1'b1;
        end
        RX_STOP: begin
          if (frame_err) begin
            if (rx_line) rx_state <= RX_IDLE;
          end else if (rx_cnt == CNT_LAST) begin
            rx_cnt <= '0;
            if (rx_line) begin
              rx_valid <= 1'b1;
              rx_state <= RX_IDLE;
            end else frame_err <= 1'b1;
          end else rx_cnt <= rx_cnt + 1'b1;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n)    led <= '0;
    else if (rx_valid) led <= rx_byte[LED_W-1:0];
  end

  if (ECHO != 0) begin : g_echo
    logic       buf_full;
    logic [7:0] buf_data;
    logic       tx_busy;
    logic       tx_start;
    logic       drain;
    logic       load_new;
    logic [7:0] tx_data;

    // A byte arriving while the buffer drains takes the freed slot.
    assign drain    = buf_full && !tx_busy;
    assign load_new = rx_valid && !tx_busy && !buf_full;
    assign tx_start = drain || load_new;
    assign tx_data  = drain ? buf_data : rx_byte;

    always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n)              buf_full <= 1'b0;
      else if (drain)              buf_full <= rx_valid;
      else if (rx_valid && tx_busy) buf_full <= 1'b1;
    end

    always_ff @(posedge clk) begin
      if (rx_valid && (drain || (tx_busy && !buf_full))) buf_data <= rx_byte;
    end

    uart_tx #(.CLKS_PER_BIT(CPB)) u_tx (
      .clk   (clk),
      .rst_n (sys_rst_n),
      .data  (tx_data),
      .start (tx_start),
      .busy  (tx_busy),
      .tx    (usb_tx)
    );
  end else begin : g_no_echo
    assign usb_tx = 1'b1;
  end

endmodule

// File: tb/tb_cu_uart_echo_top.sv
// Directed bench for cu_uart_echo_top at 100 clocks per bit with ECHO enabled.
module tb_cu_uart_echo_top;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       usb_rx = 1'b1;
  logic       usb_tx;
  logic [7:0] led;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int tx_falls = 0;
  logic [7:0] echo_q[$];
  int         echo_cyc_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge usb_tx) if (rst_n) tx_falls++;

  cu_uart_echo_top #(
    .CLK_HZ (100000000),
    .BAUD   (1000000),
    .LED_W  (8),
    .ECHO   (1)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .usb_rx (usb_rx),
    .usb_tx (usb_tx),
    .led    (led)
  );

  // Decodes frames on usb_tx, sampling mid-bit at the nominal 100 clk/bit.
  initial begin : mon
    logic [7:0] b;
    int         sc;
    b  = '0;
    sc = 0;
    forever begin
      @(negedge usb_tx);
      sc = cyc;
      repeat (50) @(negedge clk);
      if (usb_tx === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (100) @(negedge clk);
          b[i] = usb_tx;
        end
        repeat (100) @(negedge clk);
        if (usb_tx === 1'b1) begin
          echo_q.push_back(b);
          echo_cyc_q.push_back(sc);
        end
      end
    end
  end

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input int bc, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      usb_rx = fr[i];
      repeat (bc) @(negedge clk);
    end
    usb_rx = 1'b1;
  endtask

  task automatic wait_echoes(input int n, input int bound);
    for (int i = 0; i < bound && echo_q.size() < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    usb_rx = 1'b1;
    repeat (5) @(negedge clk);
    compared++;
    if (usb_tx !== 1'b1) begin
      $display("FAIL reset_tx: got %b expected 1", usb_tx); mismatched++;
    end
    compared++;
    if (led !== 8'h00) begin
      $display("FAIL reset_led: got %h expected 00", led); mismatched++;
    end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_single();
    int t0, led_cyc, d;
    echo_q.delete(); echo_cyc_q.delete();
    t0 = cyc;
    led_cyc = 0;
    fork
      send_byte(8'hA5, 100, 1'b1);
      begin
        for (int i = 0; i < 1200 && led !== 8'hA5; i++) @(negedge clk);
        led_cyc = cyc;
      end
    join
    compared++;
    if (led !== 8'hA5) begin
      $display("FAIL single_led: got %h expected a5", led); mismatched++;
    end
    compared++;
    if (led_cyc - t0 < 940 || led_cyc - t0 > 970) begin
      $display("FAIL single_led_latency: got %0d clk expected 940..970", led_cyc - t0); mismatched++;
    end
    wait_echoes(1, 1500);
    compared++;
    if (echo_q.size() != 1) begin
      $display("FAIL single_echo_count: got %0d expected 1", echo_q.size()); mismatched++;
    end else begin
      compared++;
      if (echo_q[0] !== 8'hA5) begin
        $display("FAIL single_echo_byte: got %h expected a5", echo_q[0]); mismatched++;
      end
      d = echo_cyc_q[0] - led_cyc;
      compared++;
      if (d < -2 || d > 2) begin
        $display("FAIL single_echo_latency: got %0d clk from led update expected within 2", d); mismatched++;
      end
    end
  endtask

  task automatic test_stream(input string name, input logic [7:0] first, input int n, input int bc);
    logic [7:0] e;
    echo_q.delete(); echo_cyc_q.delete();
    for (int k = 0; k < n; k++) send_byte(first + 8'(k), bc, 1'b1);
    wait_echoes(n, 3000);
    compared++;
    if (echo_q.size() != n) begin
      $display("FAIL %s_count: got %0d expected %0d", name, echo_q.size(), n); mismatched++;
    end
    for (int k = 0; k < n && k < echo_q.size(); k++) begin
      e = first + 8'(k);
      compared++;
      if (echo_q[k] !== e) begin
        $display("FAIL %s_byte%0d: got %h expected %h", name, k, echo_q[k], e); mismatched++;
      end
    end
    e = first + 8'(n - 1);
    compared++;
    if (led !== e) begin
      $display("FAIL %s_led: got %h expected %h", name, led, e); mismatched++;
    end
  endtask

  task automatic test_glitch();
    int f0;
    echo_q.delete(); echo_cyc_q.delete();
    f0 = tx_falls;
    usb_rx = 1'b0;
    repeat (30) @(negedge clk);
    usb_rx = 1'b1;
    repeat (1500) @(negedge clk);
    compared++;
    if (led !== 8'h13) begin
      $display("FAIL glitch_led: got %h expected 13", led); mismatched++;
    end
    compared++;
    if (echo_q.size() != 0) begin
      $display("FAIL glitch_echo: got %0d frames expected 0", echo_q.size()); mismatched++;
    end
    compared++;
    if (tx_falls != f0) begin
      $display("FAIL glitch_tx_edges: got %0d expected %0d", tx_falls, f0); mismatched++;
    end
    compared++;
    if (usb_tx !== 1'b1) begin
      $display("FAIL glitch_tx_idle: got %b expected 1", usb_tx); mismatched++;
    end
  endtask

  task automatic test_framing();
    echo_q.delete(); echo_cyc_q.delete();
    send_byte(8'h3C, 100, 1'b0);
    repeat (1500) @(negedge clk);
    compared++;
    if (led !== 8'h13) begin
      $display("FAIL framing_led: got %h expected 13", led); mismatched++;
    end
    compared++;
    if (echo_q.size() != 0) begin
      $display("FAIL framing_echo: got %0d frames expected 0", echo_q.size()); mismatched++;
    end
    send_byte(8'h55, 100, 1'b1);
    wait_echoes(1, 2000);
    compared++;
    if (echo_q.size() != 1 || echo_q[0] !== 8'h55) begin
      $display("FAIL framing_recover_echo: got %0d frames first %h expected 1 frame 55",
               echo_q.size(), (echo_q.size() > 0) ? echo_q[0] : 8'hxx);
      mismatched++;
    end
    compared++;
    if (led !== 8'h55) begin
      $display("FAIL framing_recover_led: got %h expected 55", led); mismatched++;
    end
  endtask

  task automatic test_reset_mid_tx();
    int f0;
    send_byte(8'h81, 100, 1'b1);
    repeat (300) @(negedge clk);
    compared++;
    if (usb_tx !== 1'b0) begin
      $display("FAIL midtx_pre: got %b expected 0 (data bit 2 of 0x81)", usb_tx); mismatched++;
    end
    usb_rx = 1'b0;
    rst_n  = 1'b0;
    #1;
    compared++;
    if (usb_tx !== 1'b1) begin
      $display("FAIL midtx_reset_tx: got %b expected 1", usb_tx); mismatched++;
    end
    compared++;
    if (led !== 8'h00) begin
      $display("FAIL midtx_reset_led: got %h expected 00", led); mismatched++;
    end
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    f0 = tx_falls;
    repeat (300) @(negedge clk);
    usb_rx = 1'b1;
    repeat (1500) @(negedge clk);
    compared++;
    if (led !== 8'h00) begin
      $display("FAIL no_false_start_led: got %h expected 00", led); mismatched++;
    end
    compared++;
    if (tx_falls != f0) begin
      $display("FAIL no_false_start_tx: got %0d edges expected %0d", tx_falls, f0); mismatched++;
    end
    echo_q.delete(); echo_cyc_q.delete();
    send_byte(8'h7E, 100, 1'b1);
    wait_echoes(1, 2000);
    compared++;
    if (echo_q.size() != 1 || echo_q[0] !== 8'h7E) begin
      $display("FAIL after_reset_echo: got %0d frames first %h expected 1 frame 7e",
               echo_q.size(), (echo_q.size() > 0) ? echo_q[0] : 8'hxx);
      mismatched++;
    end
    compared++;
    if (led !== 8'h7E) begin
      $display("FAIL after_reset_led: got %h expected 7e", led); mismatched++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream("b2b", 8'h01, 3, 100);
    test_stream("fast", 8'h10, 4, 97);
    test_glitch();
    test_framing();
    test_reset_mid_tx();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
